// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions: add/subtract mode encoding and signed saturation limits.
package mips_alu_pkg;

    // Mode select carried on the Sub input of the adder.
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } alu_mode_e;

    // Widest datapath the saturation helper supports.
    localparam int MAX_WIDTH = 64;

    // Signed max (negative=0) or signed min (negative=1) for a width-bit word,
    // returned zero-extended to MAX_WIDTH bits.
    function automatic logic [MAX_WIDTH-1:0] signed_limit(input int width, input logic negative);
        logic [MAX_WIDTH-1:0] msb_only;
        msb_only = MAX_WIDTH'(1) << (width - 1);
        signed_limit = negative ? msb_only : (msb_only - MAX_WIDTH'(1));
    endfunction

endpackage

// File: rtl/adder_slice.sv
// One pipeline stage of the adder: S-bit add with carry-in, plus the stage
// register (valid, sum slice, carry-out, pass-through token payload).
// The stage loads whenever it is empty or its successor can take its token.
module adder_slice #(
    parameter int S  = 16,
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [S-1:0]  a,
    input  logic [S-1:0]  b,
    input  logic          cin,
    input  logic [PW-1:0] payload_in,
    input  logic          down_ready,
    output logic          valid_reg,
    output logic [S-1:0]  sum_reg,
    output logic          carry_reg,
    output logic [PW-1:0] payload_reg
);

    logic [S:0] sum_next;

    assign sum_next = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, cin};

    // Empty or advancing this cycle: the stage can take a new token.
    assign in_ready = !valid_reg || down_ready;

    // Stage register; a bubble arriving while ready simply clears valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg   <= 1'b0;
            sum_reg     <= '0;
            carry_reg   <= 1'b0;
            payload_reg <= '0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                sum_reg     <= sum_next[S-1:0];
                carry_reg   <= sum_next[S];
                payload_reg <= payload_in;
            end
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined two's-complement add/subtract with valid/ready flow control.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits; each token
// carries its not-yet-added operand bits and already-finished sum bits.
// Optional saturation on signed overflow: define PIPELINED_ADDER_SAT_EN.
module pipelined_adder
    import mips_alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Sub,
    input  logic             Cin,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             Sat,
`endif
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Out,
    output logic             Cout,
    output logic             Ovf,
    output logic             Zero
);

    localparam int S    = WIDTH / STAGES;
    // Token payload: {sat, A, B', finished sum bits}
    localparam int PW   = 3 * WIDTH + 1;
    localparam int LAST = STAGES - 1;

    localparam logic [MAX_WIDTH-1:0] SMAX_FULL = signed_limit(WIDTH, 1'b0);
    localparam logic [MAX_WIDTH-1:0] SMIN_FULL = signed_limit(WIDTH, 1'b1);
    localparam logic [WIDTH-1:0]     SMAX      = SMAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     SMIN      = SMIN_FULL[WIDTH-1:0];

    generate
        if (STAGES < 1 || STAGES > 8 || (WIDTH % STAGES) != 0 || WIDTH > MAX_WIDTH) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES must be 1..8");
        end
    endgenerate

    logic             sat_in;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

`ifdef PIPELINED_ADDER_SAT_EN
    assign sat_in = Sat;
`else
    assign sat_in = 1'b0;
`endif

    // Subtraction is A + ~B + 1; the +1 enters as stage 0's carry.
    assign b_eff = (Sub == MODE_SUB) ? ~B : B;
    assign cin0  = (Sub == MODE_SUB) ? 1'b1 : Cin;

    logic [STAGES-1:0] stg_vin;
    logic [STAGES-1:0] stg_cin;
    logic [STAGES-1:0] stg_down;
    logic [STAGES-1:0] stg_ready;
    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_carry;
    logic [S-1:0]      stg_a    [STAGES];
    logic [S-1:0]      stg_b    [STAGES];
    logic [S-1:0]      stg_sum  [STAGES];
    logic [PW-1:0]     pay_in   [STAGES];
    logic [PW-1:0]     pay_q    [STAGES];
    logic [WIDTH-1:0]  done_sum [STAGES];
    logic [STAGES-1:0] unused_stage_bits;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stg_vin[gi] = InValid;
                assign stg_a[gi]   = A[S-1:0];
                assign stg_b[gi]   = b_eff[S-1:0];
                assign stg_cin[gi] = cin0;
                assign pay_in[gi]  = {sat_in, A, b_eff, {WIDTH{1'b0}}};
            end else begin : g_next
                assign stg_vin[gi] = stg_valid[gi-1];
                assign stg_a[gi]   = pay_q[gi-1][2*WIDTH + gi*S +: S];
                assign stg_b[gi]   = pay_q[gi-1][WIDTH + gi*S +: S];
                assign stg_cin[gi] = stg_carry[gi-1];
                assign pay_in[gi]  = {pay_q[gi-1][PW-1:WIDTH], done_sum[gi-1]};
            end

            // Successor can take a token if any stage from it to the end has
            // a hole, or the consumer drains the output. Written in closed
            // form so ready never depends on other ready signals.
            if (gi == LAST) begin : g_down_last
                assign stg_down[gi] = OutReady;
            end else begin : g_down_mid
                assign stg_down[gi] = OutReady || !(&stg_valid[LAST:gi+1]);
            end

            adder_slice #(
                .S  (S),
                .PW (PW)
            ) u_slice (
                .clk         (Clk),
                .rst_n       (Rst_n),
                .in_valid    (stg_vin[gi]),
                .in_ready    (stg_ready[gi]),
                .a           (stg_a[gi]),
                .b           (stg_b[gi]),
                .cin         (stg_cin[gi]),
                .payload_in  (pay_in[gi]),
                .down_ready  (stg_down[gi]),
                .valid_reg   (stg_valid[gi]),
                .sum_reg     (stg_sum[gi]),
                .carry_reg   (stg_carry[gi]),
                .payload_reg (pay_q[gi])
            );

            // Merge this stage's fresh slice into the finished-sum bits.
            assign done_sum[gi] = pay_q[gi][WIDTH-1:0] | (WIDTH'(stg_sum[gi]) << (gi * S));

            // Operand bits already consumed and later-stage ready outputs
            // are not needed downstream.
            assign unused_stage_bits[gi] = ^{pay_q[gi], stg_ready[gi]};
        end
    endgenerate

    logic [WIDTH-1:0] sum_raw;
    logic             a_msb;
    logic             b_msb;
    logic             ovf;
    logic             sat_last;

    assign sum_raw  = done_sum[LAST];
    assign a_msb    = pay_q[LAST][3*WIDTH-1];
    assign b_msb    = pay_q[LAST][2*WIDTH-1];
    assign sat_last = pay_q[LAST][PW-1];

    // Same-sign operands producing a different-sign result overflowed.
    assign ovf = (a_msb == b_msb) && (sum_raw[WIDTH-1] != a_msb);

`ifdef PIPELINED_ADDER_SAT_EN
    assign Out = (sat_last && ovf) ? (a_msb ? SMIN : SMAX) : sum_raw;
`else
    assign Out = sum_raw;
`endif

    assign InReady  = stg_ready[0];
    assign OutValid = stg_valid[LAST];
    assign Cout     = stg_carry[LAST];
    assign Ovf      = ovf;
    // Qualified by valid so an empty pipeline reports Zero=0.
    assign Zero     = stg_valid[LAST] && (Out == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: a 32-bit/2-stage instance for
// directed, backpressure and reset scenarios, and a 16-bit/4-stage instance
// for random traffic. Expected results are queued when an operation is
// accepted and compared when the matching result is consumed.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam bit SAT_BUILD = 1'b1;
`else
    localparam bit SAT_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] out;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, sub, cin, sat, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, out;

    logic        in_valid4, in_ready4, sub4, cin4, sat4, out_valid4, out_ready4, cout4, ovf4, zero4;
    logic [15:0] a4, b4, out4;

    res_t q2[$];
    res_t q4[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [31:0] dir_a [8] = '{32'h0000_0005, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0007, 32'h0000_0003};
    logic [31:0] dir_b [8] = '{32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                               32'h0000_0001, 32'h0000_0000, 32'h0000_0007, 32'h0000_0005};
    logic [7:0]  dir_sub   = 8'b1101_1000;
    logic [7:0]  dir_cin   = 8'b0110_0000;
    logic [7:0]  dir_sat   = 8'b0011_0000;

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .InValid  (in_valid),
        .InReady  (in_ready),
        .A        (a),
        .B        (b),
        .Sub      (sub),
        .Cin      (cin),
`ifdef PIPELINED_ADDER_SAT_EN
        .Sat      (sat),
`endif
        .OutValid (out_valid),
        .OutReady (out_ready),
        .Out      (out),
        .Cout     (cout),
        .Ovf      (ovf),
        .Zero     (zero)
    );

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut4 (
        .Clk      (clk),
        .Rst_n    (rst_n),
        .InValid  (in_valid4),
        .InReady  (in_ready4),
        .A        (a4),
        .B        (b4),
        .Sub      (sub4),
        .Cin      (cin4),
`ifdef PIPELINED_ADDER_SAT_EN
        .Sat      (sat4),
`endif
        .OutValid (out_valid4),
        .OutReady (out_ready4),
        .Out      (out4),
        .Cout     (cout4),
        .Ovf      (ovf4),
        .Zero     (zero4)
    );

    // Reference: exact signed arithmetic for overflow, unsigned for carry.
    function automatic res_t model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                   input logic subi, input logic cini, input logic sati);
        longint mask, ua, ub, sa, sb, t, u, hi, lo;
        res_t   r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(ai) & mask;
        ub   = longint'(bi) & mask;
        sa   = ai[w-1] ? ua - (longint'(1) << w) : ua;
        sb   = bi[w-1] ? ub - (longint'(1) << w) : ub;
        t    = subi ? (sa - sb) : (sa + sb + longint'(cini));
        u    = ua + (subi ? (mask - ub) : ub) + ((subi || cini) ? 1 : 0);
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        r.cout = u[w];
        r.ovf  = (t > hi) || (t < lo);
        r.out  = 32'(u & mask);
        if (SAT_BUILD && sati && r.ovf)
            r.out = (sa < 0) ? 32'(lo & mask) : 32'(hi);
        r.zero = (r.out == 32'h0);
        return r;
    endfunction

    task automatic push2();
        q2.push_back(model(32, a, b, sub, cin, sat));
    endtask

    task automatic push4();
        q4.push_back(model(16, {16'h0, a4}, {16'h0, b4}, sub4, cin4, sat4));
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || out_valid4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b/%b expected 0/0", out_valid, out_valid4);
        end
        n_checks++;
        if ({out, cout, ovf, zero} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h c=%b v=%b z=%b expected all 0", out, cout, ovf, zero);
        end
        n_checks++;
        if ({out4, cout4, ovf4, zero4} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_outputs4: got out=%h c=%b v=%b z=%b expected all 0", out4, cout4, ovf4, zero4);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || in_ready4 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b/%b expected 1/1", in_ready, in_ready4);
        end
    endtask

    task automatic test_directed();
        res_t exp_r, got_r;
        int   lat;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            a = dir_a[i]; b = dir_b[i]; sub = dir_sub[i]; cin = dir_cin[i]; sat = dir_sat[i];
            in_valid = 1'b1; out_ready = 1'b1;
            push2();
            lat = 0;
            for (int n = 1; n <= 10 && lat == 0; n++) begin
                @(posedge clk);
                #1;
                if (n == 1) in_valid = 1'b0;
                if (out_valid === 1'b1) lat = n;
            end
            n_checks++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL dir_latency[%0d]: got %0d cycles expected 2", i, lat);
            end
            exp_r = q2.pop_front();
            got_r = '{out: out, cout: cout, ovf: ovf, zero: zero};
            n_checks++;
            if (got_r !== exp_r) begin
                n_fail++;
                $display("FAIL dir_result[%0d]: got out=%h c=%b v=%b z=%b expected out=%h c=%b v=%b z=%b",
                         i, got_r.out, got_r.cout, got_r.ovf, got_r.zero,
                         exp_r.out, exp_r.cout, exp_r.ovf, exp_r.zero);
            end
            $display("dir %0d: a=%h b=%h sub=%b cin=%b sat=%b -> out=%h c=%b v=%b z=%b",
                     i, dir_a[i], dir_b[i], dir_sub[i], dir_cin[i], dir_sat[i],
                     got_r.out, got_r.cout, got_r.ovf, got_r.zero);
        end
    endtask

    task automatic test_back_to_back();
        res_t exp_r, got_r, held_r;
        logic held_valid = 1'b0;
        logic exp_rdy;
        int   idx = 0;
        int   popped = 0;
        int   cyc = 0;
        while (popped < 6 && cyc < 60) begin
            @(posedge clk);
            #1;
            if (idx < 6) begin
                a = 32'h1000_0000 * idx + 32'h0001_FFFF;
                b = 32'h0000_0101 * (idx + 1);
                sub = idx[0]; cin = idx[1]; sat = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
            cyc++;
            @(negedge clk);
            exp_rdy = (q2.size() < 2) || out_ready;
            n_checks++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
            end
            got_r = '{out: out, cout: cout, ovf: ovf, zero: zero};
            if (held_valid) begin
                n_checks++;
                if (out_valid !== 1'b1 || got_r !== held_r) begin
                    n_fail++;
                    $display("FAIL b2b_hold cyc %0d: got valid=%b out=%h expected valid=1 out=%h",
                             cyc, out_valid, got_r.out, held_r.out);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got out=%h expected no result", got_r.out);
                end else begin
                    exp_r = q2.pop_front();
                    if (got_r !== exp_r) begin
                        n_fail++;
                        $display("FAIL b2b_result[%0d]: got out=%h c=%b v=%b z=%b expected out=%h c=%b v=%b z=%b",
                                 popped, got_r.out, got_r.cout, got_r.ovf, got_r.zero,
                                 exp_r.out, exp_r.cout, exp_r.ovf, exp_r.zero);
                    end
                end
                $display("b2b %0d: out=%h c=%b v=%b z=%b", popped, got_r.out, got_r.cout, got_r.ovf, got_r.zero);
                popped++;
            end
            held_valid = out_valid && !out_ready;
            held_r     = got_r;
            if (in_valid && in_ready) begin
                push2();
                idx++;
            end
        end
        n_checks++;
        if (popped != 6 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d results (%0d left) expected 6 (0 left)", popped, q2.size());
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        @(posedge clk);
        #1;
        a = 32'h0000_1111; b = 32'h0000_2222; sub = 1'b0; cin = 1'b0; sat = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 a = 32'h0000_3333;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_inflight: got out_valid=%b expected 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got out_valid=%b expected 0", out_valid);
        end
        q2.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_ghost cyc %0d: got out_valid=%b expected 0", n, out_valid);
            end
        end
        $display("midrst: two tokens discarded by reset");
    endtask

    task automatic test_random4();
        res_t exp_r, got_r;
        int   lat = 0;
        int   issued = 0;
        int   done = 0;
        int   cyc = 0;
        int   bad = 0;
        logic need_new = 1'b1;
        // Latency on an idle 4-stage pipeline.
        @(posedge clk);
        #1;
        a4 = 16'h7FFF; b4 = 16'h0001; sub4 = 1'b0; cin4 = 1'b0; sat4 = 1'b0;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        push4();
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid4 = 1'b0;
            if (out_valid4 === 1'b1) lat = n;
        end
        n_checks++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL rand_latency: got %0d cycles expected 4", lat);
        end
        exp_r = q4.pop_front();
        got_r = '{out: {16'h0, out4}, cout: cout4, ovf: ovf4, zero: zero4};
        n_checks++;
        if (got_r !== exp_r) begin
            n_fail++;
            $display("FAIL rand_first: got out=%h c=%b v=%b z=%b expected out=%h c=%b v=%b z=%b",
                     got_r.out, got_r.cout, got_r.ovf, got_r.zero, exp_r.out, exp_r.cout, exp_r.ovf, exp_r.zero);
        end
        while ((issued < 10000 || done < 10000) && cyc < 40000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (need_new) begin
                if (issued < 10000 && $urandom_range(0, 9) < 8) begin
                    a4 = 16'($urandom); b4 = 16'($urandom);
                    sub4 = 1'($urandom); cin4 = 1'($urandom); sat4 = 1'($urandom);
                    in_valid4 = 1'b1;
                end else begin
                    in_valid4 = 1'b0;
                end
            end
            out_ready4 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (out_valid4 && out_ready4) begin
                got_r = '{out: {16'h0, out4}, cout: cout4, ovf: ovf4, zero: zero4};
                n_checks++;
                if (q4.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_extra: got out=%h expected no result", got_r.out);
                end else begin
                    exp_r = q4.pop_front();
                    if (got_r !== exp_r) begin
                        n_fail++;
                        bad++;
                        $display("FAIL rand_result[%0d]: got out=%h c=%b v=%b z=%b expected out=%h c=%b v=%b z=%b",
                                 done, got_r.out, got_r.cout, got_r.ovf, got_r.zero,
                                 exp_r.out, exp_r.cout, exp_r.ovf, exp_r.zero);
                    end
                end
                done++;
            end
            if (in_valid4 && in_ready4) begin
                push4();
                issued++;
            end
            need_new = !in_valid4 || in_ready4;
        end
        n_checks++;
        if (done != 10000 || q4.size() != 0) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results (%0d left) expected 10000 (0 left)", done, q4.size());
        end
        $display("rand: %0d ops issued, %0d results, %0d wrong, %0d cycles", issued, done, bad, cyc);
        in_valid4 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; cin = 1'b0; sat = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; sub4 = 1'b0; cin4 = 1'b0; sat4 = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midflight();
        test_random4();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
